// File: rtl/tqvp_bus_initiator.sv
// tqvp_bus_initiator: single-outstanding command-to-peripheral bus initiator.
// Accepts one command, drives one sized read/write access with a wait-state
// timeout, then holds the response until the consumer takes it.
module tqvp_bus_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [1:0]  cmd_size,
  input  logic [5:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic [5:0]  address,
  output logic [31:0] data_in,
  output logic [1:0]  data_write_n,
  output logic [1:0]  data_read_n,
  input  logic [31:0] data_out,
  input  logic        data_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_status
);

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 8;

  localparam logic [1:0] STB_IDLE    = 2'b11;
  localparam logic [1:0] SZ_8        = 2'b00;
  localparam logic [1:0] SZ_16       = 2'b01;
  localparam logic [1:0] SZ_ILLEGAL  = 2'b11;
  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_TIMEOUT  = 2'b01;
  localparam logic [1:0] ST_ILLEGAL  = 2'b10;

  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCESS = 2'b01,
    S_RESP   = 2'b10
  } state_e;

  state_e          state_q, state_d;
  logic            write_q, write_d;
  logic [1:0]      size_q, size_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [1:0]      wr_n_q, wr_n_d;
  logic [1:0]      rd_n_q, rd_n_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [1:0]      status_q, status_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            cmd_ready_q, cmd_ready_d;

  // Keep only the bytes covered by the access size; upper bits read as zero.
  function automatic logic [DW-1:0] mask_rdata(input logic [1:0] size, input logic [DW-1:0] d);
    logic [DW-1:0] m;
    case (size)
      SZ_8:    m = {24'd0, d[7:0]};
      SZ_16:   m = {16'd0, d[15:0]};
      default: m = d;
    endcase
    return m;
  endfunction

  // State and registered outputs; reset also drops any active strobe at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      write_q     <= 1'b0;
      size_q      <= 2'b00;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_n_q      <= STB_IDLE;
      rd_n_q      <= STB_IDLE;
      rdata_q     <= '0;
      status_q    <= ST_OK;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      size_q      <= size_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_n_q      <= wr_n_d;
      rd_n_q      <= rd_n_d;
      rdata_q     <= rdata_d;
      status_q    <= status_d;
      rsp_valid_q <= rsp_valid_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  // Next-state and next-output logic; every register holds unless changed.
  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    size_d      = size_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wr_n_d      = wr_n_q;
    rd_n_d      = rd_n_q;
    rdata_d     = rdata_q;
    status_d    = status_q;
    rsp_valid_d = rsp_valid_q;
    cmd_ready_d = cmd_ready_q;

    case (state_q)
      S_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          if (cmd_size == SZ_ILLEGAL) begin
            // Rejected without touching the bus.
            state_d     = S_RESP;
            status_d    = ST_ILLEGAL;
            rdata_d     = '0;
            rsp_valid_d = 1'b1;
          end else begin
            state_d = S_ACCESS;
            write_d = cmd_write;
            size_d  = cmd_size;
            addr_d  = cmd_addr;
            wdata_d = cmd_wdata;
            cnt_d   = '0;
            if (cmd_write) wr_n_d = cmd_size;
            else           rd_n_d = cmd_size;
          end
        end
      end

      S_ACCESS: begin
        if (data_ready) begin
          // Completion wins over a timeout firing in the same cycle.
          state_d     = S_RESP;
          status_d    = ST_OK;
          rdata_d     = write_q ? '0 : mask_rdata(size_q, data_out);
          wr_n_d      = STB_IDLE;
          rd_n_d      = STB_IDLE;
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_d     = S_RESP;
            status_d    = ST_TIMEOUT;
            rdata_d     = '0;
            wr_n_d      = STB_IDLE;
            rd_n_d      = STB_IDLE;
            rsp_valid_d = 1'b1;
          end
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end

      default: begin
        state_d     = S_IDLE;
        wr_n_d      = STB_IDLE;
        rd_n_d      = STB_IDLE;
        rsp_valid_d = 1'b0;
        cmd_ready_d = 1'b1;
      end
    endcase
  end

  assign cmd_ready    = cmd_ready_q;
  assign address      = addr_q;
  assign data_in      = wdata_q;
  assign data_write_n = wr_n_q;
  assign data_read_n  = rd_n_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rdata_q;
  assign rsp_status   = status_q;

endmodule

// File: tb/tb_tqvp_bus_initiator.sv
// Testbench for tqvp_bus_initiator: directed cases plus randomized commands
// checked against a per-transaction outcome model.
module tb_tqvp_bus_initiator;

  localparam int unsigned TMO = 4;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [1:0]  cmd_size;
  logic [5:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_status;

  int n_cmp = 0;
  int n_err = 0;

  // Last bus address/data the model expects to be held on the bus.
  logic [5:0]  last_addr  = 6'd0;
  logic [31:0] last_wdata = 32'd0;

  tqvp_bus_initiator #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_size     (cmd_size),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .address      (address),
    .data_in      (data_in),
    .data_write_n (data_write_n),
    .data_read_n  (data_read_n),
    .data_out     (data_out),
    .data_ready   (data_ready),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_status   (rsp_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   return 32'h0000_00FF;
      2'b01:   return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  // One full command: offer, bus access with peripheral latency lat
  // (cycles of data_ready=0 before it rises), then a response stalled for
  // 'stall' cycles.
  task automatic do_txn(input logic wr, input logic [1:0] sz, input logic [5:0] ad,
                        input logic [31:0] wd, input logic [31:0] dout,
                        input int lat, input int stall);
    int n;
    logic legal;
    int exp_n;
    logic [1:0] exp_status;
    logic [31:0] exp_rdata;
    legal = (sz != 2'b11);
    if (!legal) begin
      exp_n = 0; exp_status = 2'b10; exp_rdata = 32'd0;
    end else if (lat < int'(TMO)) begin
      exp_n = lat + 1; exp_status = 2'b00;
      exp_rdata = wr ? 32'd0 : (dout & size_mask(sz));
    end else begin
      exp_n = int'(TMO); exp_status = 2'b01; exp_rdata = 32'd0;
    end
    if (legal) begin
      last_addr  = ad;
      last_wdata = wd;
    end

    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_size = sz; cmd_addr = ad; cmd_wdata = wd;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_size = 2'($urandom);
    cmd_addr = 6'($urandom); cmd_wdata = $urandom;

    n = 0;
    while ((data_write_n != 2'b11 || data_read_n != 2'b11) && n < 300) begin
      n++;
      check("strobe_wr", 32'(data_write_n), (legal && wr)  ? 32'(sz) : 32'd3);
      check("strobe_rd", 32'(data_read_n),  (legal && !wr) ? 32'(sz) : 32'd3);
      check("access_addr", 32'(address), 32'(ad));
      check("access_wdata", data_in, wd);
      check("access_cmd_ready", 32'(cmd_ready), 32'd0);
      check("access_rsp_valid", 32'(rsp_valid), 32'd0);
      data_ready = ((n - 1) == lat);
      data_out   = data_ready ? dout : $urandom;
      @(posedge clk); @(negedge clk);
    end
    check("strobe_cycles", 32'(n), 32'(exp_n));

    for (int s = 0; s <= stall; s++) begin
      check("rsp_valid", 32'(rsp_valid), 32'd1);
      check("rsp_status", 32'(rsp_status), 32'(exp_status));
      check("rsp_rdata", rsp_rdata, exp_rdata);
      check("resp_cmd_ready", 32'(cmd_ready), 32'd0);
      check("resp_strobe_wr", 32'(data_write_n), 32'd3);
      check("resp_strobe_rd", 32'(data_read_n), 32'd3);
      check("hold_addr", 32'(address), 32'(last_addr));
      check("hold_wdata", data_in, last_wdata);
      rsp_ready  = (s == stall);
      data_ready = 1'($urandom);
      data_out   = $urandom;
      @(posedge clk); @(negedge clk);
    end
    rsp_ready = 1'b0;
    check("post_rsp_valid", 32'(rsp_valid), 32'd0);
    check("post_cmd_ready", 32'(cmd_ready), 32'd1);
  endtask

  // Idle cycles with noise on peripheral inputs, which must be ignored.
  task automatic idle_gap(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      data_ready = 1'($urandom);
      data_out   = $urandom;
      check("gap_cmd_ready", 32'(cmd_ready), 32'd1);
      check("gap_rsp_valid", 32'(rsp_valid), 32'd0);
      check("gap_strobe", 32'({data_write_n, data_read_n}), 32'hF);
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_wr"}, 32'(data_write_n), 32'd3);
    check({tag, "_rd"}, 32'(data_read_n), 32'd3);
    check({tag, "_addr"}, 32'(address), 32'd0);
    check({tag, "_wdata"}, data_in, 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rdata"}, rsp_rdata, 32'd0);
    check({tag, "_status"}, 32'(rsp_status), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_size = 2'b00;
    cmd_addr = 6'd0; cmd_wdata = 32'd0; data_out = 32'd0; data_ready = 1'b0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_cmd_ready", 32'(cmd_ready), 32'd1);

    // 32-bit write, zero-wait peripheral.
    do_txn(1'b1, 2'b10, 6'h00, 32'hE000_000F, 32'h1234_5678, 0, 0);
    idle_gap(1);
    // 8-bit read after three wait cycles.
    do_txn(1'b0, 2'b00, 6'h18, 32'h0, 32'hDEAD_BEA5, 3, 0);
    // 16-bit read that times out, then one completing on the last cycle.
    do_txn(1'b0, 2'b01, 6'h05, 32'h0, 32'hCAFE_F00D, 100, 1);
    do_txn(1'b0, 2'b01, 6'h06, 32'h0, 32'hCAFE_F00D, 3, 0);
    // Illegal size, with a long response stall.
    do_txn(1'b0, 2'b11, 6'h3F, 32'hFFFF_FFFF, 32'h0, 0, 5);
    do_txn(1'b1, 2'b01, 6'h2A, 32'hAAAA_5555, 32'hFFFF_FFFF, 1, 5);

    // Reset pulsed in the middle of an access.
    check("rst_pre_cmd_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_size = 2'b01; cmd_addr = 6'h11;
    cmd_wdata = 32'h0; data_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    check("rst_pre_strobe", 32'(data_read_n), 32'd1);
    @(posedge clk); @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_values("midreset");
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    last_addr = 6'd0; last_wdata = 32'd0;
    idle_gap(3);
    do_txn(1'b0, 2'b10, 6'h22, 32'h0, 32'h8765_4321, 2, 0);

    // Randomized commands.
    for (int t = 0; t < 200; t++) begin
      do_txn(1'($urandom), 2'($urandom), 6'($urandom), $urandom, $urandom,
             int'($urandom_range(0, 6)), int'($urandom_range(0, 3)));
      idle_gap(int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
